rail_sensor_detect: RTL

//  Upstream stage of the railway crossing controller; produces its rail_detect input.
//  Two trackside sensors flank the crossing zone. sensor_in is the approach sensor and

---
 rtl/rail_pkg.sv | 16 +
 rtl/sensor_debounce.sv | 66 ++++++
 rtl/rail_sensor_detect.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rail_pkg.sv
// Shared definitions for the rail detection chain and the crossing controller.
package rail_pkg;

    // Detector FSM encodings; code 3 is never produced and recovers to FAULT.
    typedef enum logic [1:0] {
        DET_IDLE    = 2'd0,
        DET_OCC     = 2'd1,
        DET_FAULT   = 2'd2,
        DET_ILLEGAL = 2'd3
    } det_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_CNT_W           = 3;
    localparam int unsigned DEF_OCC_TIMEOUT     = 1000;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser, debouncer and one-cycle rising-edge pulse for one trackside sensor.
module sensor_debounce
    import rail_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_deb,
    output logic o_rise
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          r_deb_d;
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_flip;

    assign w_diff = r_sync2 ^ r_deb;
    // The toggle edge is the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
    assign w_flip = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

    // Bring the asynchronous raw sensor into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreement and flip the debounced level when it persists.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_deb <= 1'b0;
        end else if (!w_diff) begin
            r_cnt <= '0;
        end else if (w_flip) begin
            r_cnt <= '0;
            r_deb <= ~r_deb;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_deb_d <= 1'b0;
        end else begin
            r_deb_d <= r_deb;
        end
    end

    assign o_deb  = r_deb;
    assign o_rise = r_deb & ~r_deb_d;

endmodule

// File: rtl/rail_sensor_detect.sv
// Zone occupancy tracker: counts trains in/out between two sensors, fail-safe FAULT latch.
module rail_sensor_detect
    import rail_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter int unsigned OCC_TIMEOUT     = DEF_OCC_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_in,
    input  logic             sensor_out,
    input  logic             fault_clr,
    output logic             rail_detect,
    output logic [CNT_W-1:0] occupancy,
    output logic             fault,
    output logic [1:0]       det_state
);

    localparam int unsigned      TW      = $clog2(OCC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] OCC_MAX = '1;

    logic             w_deb_in;
    logic             w_deb_out;
    logic             w_ev_in;
    logic             w_ev_out;
    logic             w_inc;
    logic             w_dec;
    logic             w_ovf;
    logic             w_unf;

    det_state_t       r_state;
    det_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] w_occ_nxt;
    logic [TW-1:0]    r_tmr;
    logic [TW-1:0]    w_tmr_nxt;
    logic             r_rail;
    logic             r_fault;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_in (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (sensor_in),
        .o_deb  (w_deb_in),
        .o_rise (w_ev_in)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_out (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (sensor_out),
        .o_deb  (w_deb_out),
        .o_rise (w_ev_out)
    );

    // Simultaneous in/out events cancel and are never treated as over/underflow.
    assign w_inc = w_ev_in & ~w_ev_out;
    assign w_dec = w_ev_out & ~w_ev_in;
    assign w_ovf = w_inc && (r_occ == OCC_MAX);
    assign w_unf = w_dec && (r_occ == '0);

    // State, occupancy, timer and decoded outputs all advance on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= DET_IDLE;
            r_occ   <= '0;
            r_tmr   <= '0;
            r_rail  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_occ   <= w_occ_nxt;
            r_tmr   <= w_tmr_nxt;
            r_rail  <= (w_state_nxt != DET_IDLE);
            r_fault <= (w_state_nxt == DET_FAULT);
        end
    end

    // Next-state, occupancy update and occupancy timer.
    always_comb begin
        w_state_nxt = r_state;
        w_occ_nxt   = r_occ;
        w_tmr_nxt   = '0;
        case (r_state)
            DET_IDLE: begin
                if (w_ovf || w_unf) begin
                    w_state_nxt = DET_FAULT;
                end else if (w_inc) begin
                    w_occ_nxt   = r_occ + 1'b1;
                    w_state_nxt = DET_OCC;
                end
            end
            DET_OCC: begin
                if (w_ovf || w_unf) begin
                    w_state_nxt = DET_FAULT;
                end else if (w_dec && (r_occ == CNT_W'(1))) begin
                    w_occ_nxt   = '0;
                    w_state_nxt = DET_IDLE;
                end else begin
                    if (w_inc) begin
                        w_occ_nxt = r_occ + 1'b1;
                    end
                    if (w_dec) begin
                        w_occ_nxt = r_occ - 1'b1;
                    end
                    if (r_tmr == TW'(OCC_TIMEOUT - 1)) begin
                        w_state_nxt = DET_FAULT;
                    end else begin
                        w_tmr_nxt = r_tmr + 1'b1;
                    end
                end
            end
            DET_FAULT: begin
                if (fault_clr && !w_deb_in && !w_deb_out) begin
                    w_occ_nxt   = '0;
                    w_state_nxt = DET_IDLE;
                end else begin
                    if (w_inc && !w_ovf) begin
                        w_occ_nxt = r_occ + 1'b1;
                    end
                    if (w_dec && !w_unf) begin
                        w_occ_nxt = r_occ - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = DET_FAULT;
            end
        endcase
    end

    assign rail_detect = r_rail;
    assign occupancy   = r_occ;
    assign fault       = r_fault;
    assign det_state   = r_state;

endmodule
